// File: rtl/vx_writeback_arb.sv
// Commit->writeback arbiter: merges NUM_SRCS commit streams into one register-file
// writeback stream through a main register plus a one-entry skid buffer.
module vx_writeback_arb #(
  parameter int unsigned NUM_SRCS    = 5,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned NW_BITS     = 2,
  parameter int unsigned NR_BITS     = 6,
  parameter              TYPE        = "R",
  localparam int unsigned DATAW      = NW_BITS + 32 + NUM_THREADS + NR_BITS + 32*NUM_THREADS + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRCS-1:0]       src_valid,
  input  logic [NUM_SRCS-1:0]       src_wb,
  input  logic [NUM_SRCS*DATAW-1:0] src_data,
  output logic [NUM_SRCS-1:0]       src_ready,
  output logic                      wb_valid,
  output logic [DATAW-1:0]          wb_data,
  input  logic                      wb_ready,
  output logic [31:0]               perf_wb_cnt,
  output logic [31:0]               perf_stall
);

  localparam int unsigned PTR_W     = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
  localparam bit          FIXED_PRI = (TYPE == "P");

  logic [NUM_SRCS-1:0] w_req;
  logic [NUM_SRCS-1:0] w_grant;
  logic                w_found;
  logic                w_acc;
  logic [PTR_W-1:0]    w_start;
  logic [PTR_W-1:0]    w_gidx;
  logic [DATAW-1:0]    w_gdata;

  logic [PTR_W-1:0]    r_rr_ptr;
  logic                r_m_valid;
  logic                r_s_valid;
  logic [DATAW-1:0]    r_m_data;
  logic [DATAW-1:0]    r_s_data;
  logic [31:0]         r_wb_cnt;
  logic [31:0]         r_stall_cnt;

  assign w_req   = src_valid & src_wb;
  assign w_start = FIXED_PRI ? '0 : r_rr_ptr;

  // Search from w_start upward first, then wrap to the low indices
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int i = 0; i < int'(NUM_SRCS); i++) begin
      if (!w_found && w_req[i] && (PTR_W'(i) >= w_start)) begin
        w_found = 1'b1;
        w_gidx  = PTR_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_SRCS); i++) begin
      if (!w_found && w_req[i]) begin
        w_found = 1'b1;
        w_gidx  = PTR_W'(i);
      end
    end
  end

  always_comb begin
    w_grant = '0;
    w_gdata = '0;
    for (int i = 0; i < int'(NUM_SRCS); i++) begin
      if (w_found && (w_gidx == PTR_W'(i))) begin
        w_grant[i] = 1'b1;
        w_gdata    = src_data[i*DATAW +: DATAW];
      end
    end
  end

  // Acceptance depends only on registered skid state, never on wb_ready
  assign w_acc     = w_found & ~r_s_valid & ~reset;
  assign src_ready = ~src_wb | (w_grant & {NUM_SRCS{~r_s_valid & ~reset}});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_valid   <= 1'b0;
      r_s_valid   <= 1'b0;
      r_rr_ptr    <= '0;
      r_wb_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (r_m_valid && wb_ready && r_s_valid) begin
        r_s_valid <= 1'b0;
      end else if (w_acc && (!r_m_valid || wb_ready)) begin
        r_m_valid <= 1'b1;
      end else if (w_acc) begin
        r_s_valid <= 1'b1;
      end else if (r_m_valid && wb_ready) begin
        r_m_valid <= 1'b0;
      end
      if (w_acc && !FIXED_PRI) begin
        r_rr_ptr <= (w_gidx == PTR_W'(NUM_SRCS - 1)) ? '0 : w_gidx + PTR_W'(1);
      end
      if (r_m_valid && wb_ready) begin
        r_wb_cnt <= r_wb_cnt + 32'd1;
      end
      if (r_m_valid && !wb_ready) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  // Payload registers carry no reset; they are only meaningful under their valid bits
  always_ff @(posedge clk) begin
    if (r_m_valid && wb_ready && r_s_valid) begin
      r_m_data <= r_s_data;
    end else if (w_acc && (!r_m_valid || wb_ready)) begin
      r_m_data <= w_gdata;
    end
    if (w_acc && r_m_valid && !wb_ready) begin
      r_s_data <= w_gdata;
    end
  end

  assign wb_valid    = r_m_valid;
  assign wb_data     = r_m_data;
  assign perf_wb_cnt = r_wb_cnt;
  assign perf_stall  = r_stall_cnt;

endmodule
